lane_seg_mul_share_arb: RTL and testbench
=========================================

Name: lane_seg_mul_share_arb

Overview:
Round-robin arbiter that shares one signed 16x13 multiplier among NUM_REQ requesters in the lane-segmentation datapath, such as the conv/normalise tap units that each need only an occasional product. Each requester presents its operands over a valid/ready handshake. The block grants one requester per cycle, multiplies, saturates the result to 28 bits and returns it through a registered, back-pressurable response port tagged with the requester ID. A sticky overflow flag and a saturation counter support debug.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
A_WIDTH, 16, signed operand A width
B_WIDTH, 13, signed operand B width
P_WIDTH, 28, signed result width after saturation
ID_WIDTH, 2, requester ID width; equals clog2(NUM_REQ), minimum 1

Ports:
ap_clk  in  1  clock, rising edge
ap_rst  in  1  asynchronous active-high reset
req_valid  in  NUM_REQ  per-requester operand valid
req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
req_a  in  NUM_REQ*A_WIDTH  packed signed A operands; requester i at bits [i*A_WIDTH +: A_WIDTH]
req_b  in  NUM_REQ*B_WIDTH  packed signed B operands, same packing
rsp_valid  out  1  result valid
rsp_ready  in  1  downstream accepts result
rsp_data  out  P_WIDTH  saturated signed product
rsp_id  out  ID_WIDTH  index of the requester that produced rsp_data
rsp_sat  out  1  this result was saturated
ovf_sticky  out  1  set by any saturated result; cleared by ovf_clr or reset
ovf_clr  in  1  synchronous clear of ovf_sticky and sat_cnt
sat_cnt  out  16  count of saturated results, holds at 0xFFFF

Behaviour:
- Reset (async assert, sync-safe deassert): rsp_valid=0, rsp_data=0, rsp_id=0, rsp_sat=0, ovf_sticky=0, sat_cnt=0, rr_ptr=NUM_REQ-1 so requester 0 has first priority. req_ready is combinational and is therefore 0 while rsp_valid=0 and no requests are pending.
- Output slot is free when rsp_valid=0 or rsp_ready=1 (pass-through pipelining; no bubble under continuous traffic).
- Arbitration is combinational. Search req_valid starting at rr_ptr+1 (mod NUM_REQ) and pick the first set bit as the grant. req_ready = grant one-hot AND slot free. At most one bit of req_ready is high.
- Transfer occurs on req_valid[i] & req_ready[i]. On that edge:
  - rsp_data/rsp_id/rsp_sat are loaded.
  - rsp_valid becomes 1.
  - rr_ptr becomes i.
- rr_ptr does not move without a transfer.
- Latency: 1 cycle from transfer edge to rsp_valid. Throughput: 1 result per cycle.
- Response hold: when rsp_valid=1 and rsp_ready=0, rsp_data/rsp_id/rsp_sat hold stable and all req_ready=0. When rsp_ready=1 and there is no new transfer, rsp_valid clears to 0 next cycle.
- Requesters keep req_valid and operands stable until accepted. The arbiter does not guarantee that an unaccepted request keeps its grant in the next cycle, but round-robin ordering guarantees service within NUM_REQ transfers.
- Arithmetic:
  - Full product p = signed(A) * signed(B), held at A_WIDTH+B_WIDTH = 29 bits.
  - If p > 2^(P_WIDTH-1)-1, the result is 0x7FFFFFF and rsp_sat=1.
  - If p < -2^(P_WIDTH-1), the result is 0x8000000 and rsp_sat=1.
  - Otherwise the result is p truncated to P_WIDTH, and rsp_sat=0.
  - With default widths only (-32768)*(-4096) = +2^27 saturates.
- ovf_sticky/sat_cnt update on the same transfer edge as a saturated load. If ovf_clr coincides with a saturated load, the clear wins first and the new event is then counted: ovf_sticky=1, sat_cnt=1.
- An invalid operand on a non-granted lane has no effect.
- Reset mid-operation: a pending response is discarded, and no req_ready is asserted while ap_rst=1.

Test Plan:
- Single request: req_valid=0001, a=100, b=-7, rsp_ready=1 -> req_ready=0001 same cycle; next cycle rsp_valid=1, rsp_data=-700, rsp_id=0, rsp_sat=0.
- Round-robin fairness: req_valid=1111 held for 8 cycles, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1,2,3 with one result per cycle and no bubbles.
- Back-pressure: a result is pending and rsp_ready=0 for 3 cycles with req_valid=0110 -> rsp_data/rsp_id stable, req_ready=0000; when rsp_ready rises, req_ready=0010 that same cycle.
- Saturation: a=-32768, b=-4096 -> rsp_data=0x7FFFFFF, rsp_sat=1, ovf_sticky=1, sat_cnt=1. Then a=-32768, b=4095 -> rsp_data=-134184960, rsp_sat=0.
- Clear collision: ovf_clr=1 in the same cycle as a saturated transfer -> ovf_sticky=1, sat_cnt=1 (not 2).
- Async reset: assert ap_rst mid-burst between clock edges -> rsp_valid=0 and sat_cnt=0 immediately. After release, the first grant with req_valid=1111 goes to requester 0.

Source files
------------

// File: rtl/lane_seg_mul_share_arb.sv
// Round-robin sharing of one signed multiplier among NUM_REQ requesters.
// Each accepted operand pair is multiplied, saturated to P_WIDTH bits and
// returned through a single registered, back-pressurable response slot
// tagged with the requester index. Saturation events are tracked by a
// sticky flag and a saturating 16-bit counter for debug.
module lane_seg_mul_share_arb #(
  parameter int NUM_REQ  = 4,
  parameter int A_WIDTH  = 16,
  parameter int B_WIDTH  = 13,
  parameter int P_WIDTH  = 28,
  parameter int ID_WIDTH = 2
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0]  req_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [P_WIDTH-1:0]          rsp_data,
  output logic [ID_WIDTH-1:0]         rsp_id,
  output logic                        rsp_sat,
  output logic                        ovf_sticky,
  input  logic                        ovf_clr,
  output logic [15:0]                 sat_cnt
);

  localparam int PROD_W = A_WIDTH + B_WIDTH;

  // Saturation bounds expressed at full product width so the compare is exact.
  localparam logic signed [PROD_W-1:0] P_MAX =
    {{(PROD_W-P_WIDTH+1){1'b0}}, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [PROD_W-1:0] P_MIN =
    {{(PROD_W-P_WIDTH+1){1'b1}}, {(P_WIDTH-1){1'b0}}};

  logic [ID_WIDTH-1:0]       rr_ptr;
  logic [NUM_REQ-1:0]        grant;
  logic [ID_WIDTH-1:0]       grant_idx;
  logic [ID_WIDTH-1:0]       cand;
  logic                      found;
  logic                      slot_free;
  logic                      xfer;
  logic                      sat_evt;
  logic signed [A_WIDTH-1:0] a_sel;
  logic signed [B_WIDTH-1:0] b_sel;
  logic signed [PROD_W-1:0]  prod;
  logic [P_WIDTH-1:0]        res_data;
  logic                      res_sat;

  // Round-robin search: first valid requester after the last one served.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // The output slot can take a new result when empty or being drained now;
  // nothing is accepted while reset is held.
  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = grant & {NUM_REQ{slot_free & ~ap_rst}};
  assign xfer      = found & slot_free & ~ap_rst;

  assign a_sel = req_a[grant_idx*A_WIDTH +: A_WIDTH];
  assign b_sel = req_b[grant_idx*B_WIDTH +: B_WIDTH];
  assign prod  = PROD_W'(a_sel) * PROD_W'(b_sel);

  // Clamp the full-width product into the P_WIDTH result range.
  always_comb begin
    res_data = prod[P_WIDTH-1:0];
    res_sat  = 1'b0;
    if (prod > P_MAX) begin
      res_data = {1'b0, {(P_WIDTH-1){1'b1}}};
      res_sat  = 1'b1;
    end else if (prod < P_MIN) begin
      res_data = {1'b1, {(P_WIDTH-1){1'b0}}};
      res_sat  = 1'b1;
    end
  end

  assign sat_evt = xfer & res_sat;

  // Response slot and round-robin pointer; pointer only moves on a transfer.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_sat   <= 1'b0;
      rr_ptr    <= ID_WIDTH'(NUM_REQ - 1);
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= res_data;
      rsp_id    <= grant_idx;
      rsp_sat   <= res_sat;
      rr_ptr    <= grant_idx;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Debug statistics; a clear in the same cycle as a saturation counts it anew.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      ovf_sticky <= 1'b0;
      sat_cnt    <= '0;
    end else if (ovf_clr) begin
      ovf_sticky <= sat_evt;
      sat_cnt    <= sat_evt ? 16'd1 : 16'd0;
    end else if (sat_evt) begin
      ovf_sticky <= 1'b1;
      if (sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_lane_seg_mul_share_arb.sv
// Self-checking bench: an integer-level model of the shared multiplier is
// compared against the DUT on every falling edge, and directed vectors add
// hand-computed literal expectations.
module tb_lane_seg_mul_share_arb;

  localparam int N = 4;

  logic               ap_clk;
  logic               ap_rst;
  logic [N-1:0]       req_valid;
  logic [N-1:0]       req_ready;
  logic [N*16-1:0]    req_a;
  logic [N*13-1:0]    req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [27:0]        rsp_data;
  logic [1:0]         rsp_id;
  logic               rsp_sat;
  logic               ovf_sticky;
  logic               ovf_clr;
  logic [15:0]        sat_cnt;

  logic signed [15:0] a_op [N];
  logic signed [12:0] b_op [N];

  int checks   = 0;
  int failures = 0;

  // Model state, in plain integer terms.
  bit     m_valid;
  longint m_data;
  int     m_id;
  bit     m_sat;
  bit     m_ovf;
  int     m_cnt;
  int     m_last;

  lane_seg_mul_share_arb dut (
    .ap_clk     (ap_clk),
    .ap_rst     (ap_rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_sat    (rsp_sat),
    .ovf_sticky (ovf_sticky),
    .ovf_clr    (ovf_clr),
    .sat_cnt    (sat_cnt)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  // Pack per-lane operands onto the flat buses.
  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = a_op[i];
      req_b[i*13 +: 13] = b_op[i];
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after a rising edge so they are stable at the next one.
  task automatic applyStimulus(input logic [N-1:0] v, input logic rdy, input logic clr);
    @(posedge ap_clk);
    #1;
    req_valid = v;
    rsp_ready = rdy;
    ovf_clr   = clr;
  endtask

  function automatic longint sat_prod(input longint p, output bit s);
    s = 1'b1;
    if (p > 134217727) return 134217727;
    if (p < -134217728) return -134217728;
    s = 1'b0;
    return p;
  endfunction

  // Model compare and update on each falling edge.
  always @(negedge ap_clk) begin
    bit     g_found;
    int     g;
    bit     slot;
    longint exp_ready;
    bit     s;
    longint d;
    if (ap_rst) begin
      m_valid = 0; m_data = 0; m_id = 0; m_sat = 0;
      m_ovf = 0; m_cnt = 0; m_last = N - 1;
      checkOutput("mdl_rst_req_ready", longint'(req_ready), 0);
      checkOutput("mdl_rst_rsp_valid", longint'(rsp_valid), 0);
      checkOutput("mdl_rst_sat_cnt", longint'(sat_cnt), 0);
    end else begin
      g_found = 0;
      g = 0;
      for (int k = 1; k <= N; k++) begin
        if (!g_found && req_valid[(m_last + k) % N]) begin
          g_found = 1;
          g = (m_last + k) % N;
        end
      end
      slot = !m_valid || rsp_ready;
      exp_ready = (g_found && slot) ? (longint'(1) << g) : 0;
      checkOutput("mdl_req_ready", longint'(req_ready), exp_ready);
      checkOutput("mdl_rsp_valid", longint'(rsp_valid), longint'(m_valid));
      if (m_valid) begin
        checkOutput("mdl_rsp_data", longint'($signed(rsp_data)), m_data);
        checkOutput("mdl_rsp_id", longint'(rsp_id), longint'(m_id));
        checkOutput("mdl_rsp_sat", longint'(rsp_sat), longint'(m_sat));
      end
      checkOutput("mdl_ovf_sticky", longint'(ovf_sticky), longint'(m_ovf));
      checkOutput("mdl_sat_cnt", longint'(sat_cnt), longint'(m_cnt));
      s = 0;
      if (g_found && slot) begin
        d = sat_prod(longint'(a_op[g]) * longint'(b_op[g]), s);
        m_valid = 1; m_data = d; m_id = g; m_sat = s; m_last = g;
      end else if (rsp_ready) begin
        m_valid = 0;
      end
      if (ovf_clr) begin
        m_ovf = s;
        m_cnt = s ? 1 : 0;
      end else if (s) begin
        m_ovf = 1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  initial begin
    ap_rst = 1'b1;
    req_valid = '0; rsp_ready = 1'b0; ovf_clr = 1'b0;
    for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; end
    m_valid = 0; m_data = 0; m_id = 0; m_sat = 0;
    m_ovf = 0; m_cnt = 0; m_last = N - 1;

    // Reset state.
    @(posedge ap_clk); #3;
    checkOutput("reset_rsp_valid", longint'(rsp_valid), 0);
    checkOutput("reset_rsp_data", longint'(rsp_data), 0);
    checkOutput("reset_rsp_id", longint'(rsp_id), 0);
    checkOutput("reset_ovf", longint'(ovf_sticky), 0);
    checkOutput("reset_sat_cnt", longint'(sat_cnt), 0);
    checkOutput("reset_req_ready", longint'(req_ready), 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;

    // Round-robin fairness with all lanes requesting.
    for (int i = 0; i < N; i++) begin
      a_op[i] = 16'(100 * (i + 1));
      b_op[i] = 13'(-(i + 3));
    end
    for (int c = 0; c <= 8; c++) begin
      applyStimulus((c < 8) ? 4'hF : 4'h0, 1'b1, 1'b0);
      #3;
      if (c == 0) checkOutput("rr_first_grant", longint'(req_ready), 1);
      if (c > 0) begin
        checkOutput("rr_rsp_valid", longint'(rsp_valid), 1);
        checkOutput("rr_rsp_id", longint'(rsp_id), (c - 1) % 4);
      end
    end

    // Single request, then back-pressure with lanes 1 and 2 waiting.
    applyStimulus(4'b0001, 1'b1, 1'b0);
    a_op[0] = 16'sd100; b_op[0] = -13'sd7;
    #3;
    checkOutput("single_req_ready", longint'(req_ready), 1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(4'b0110, 1'b0, 1'b0);
      #3;
      checkOutput("bp_rsp_valid", longint'(rsp_valid), 1);
      checkOutput("bp_rsp_data", longint'($signed(rsp_data)), -700);
      checkOutput("bp_rsp_id", longint'(rsp_id), 0);
      checkOutput("bp_rsp_sat", longint'(rsp_sat), 0);
      checkOutput("bp_req_ready", longint'(req_ready), 0);
    end
    applyStimulus(4'b0110, 1'b1, 1'b0);
    #3;
    checkOutput("bp_release_ready", longint'(req_ready), 4'b0010);
    applyStimulus(4'b0100, 1'b1, 1'b0);
    #3;
    checkOutput("bp_lane1_data", longint'($signed(rsp_data)), -800);
    checkOutput("bp_lane1_id", longint'(rsp_id), 1);
    checkOutput("bp_lane2_ready", longint'(req_ready), 4'b0100);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #3;
    checkOutput("bp_lane2_id", longint'(rsp_id), 2);
    checkOutput("bp_lane2_data", longint'($signed(rsp_data)), -1500);

    // Saturation and the largest non-saturating neighbour.
    applyStimulus(4'b0001, 1'b1, 1'b0);
    a_op[0] = -16'sd32768; b_op[0] = -13'sd4096;
    #3;
    applyStimulus(4'b0001, 1'b1, 1'b0);
    b_op[0] = 13'sd4095;
    #3;
    checkOutput("sat_pos_data", longint'(rsp_data), 28'h7FFFFFF);
    checkOutput("sat_pos_flag", longint'(rsp_sat), 1);
    checkOutput("sat_pos_ovf", longint'(ovf_sticky), 1);
    checkOutput("sat_pos_cnt", longint'(sat_cnt), 1);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #3;
    checkOutput("nosat_data", longint'($signed(rsp_data)), -134184960);
    checkOutput("nosat_flag", longint'(rsp_sat), 0);
    checkOutput("nosat_cnt", longint'(sat_cnt), 1);

    // Clear coinciding with a saturated transfer.
    applyStimulus(4'b0001, 1'b1, 1'b1);
    b_op[0] = -13'sd4096;
    #3;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #3;
    checkOutput("clr_collide_ovf", longint'(ovf_sticky), 1);
    checkOutput("clr_collide_cnt", longint'(sat_cnt), 1);
    applyStimulus(4'b0000, 1'b1, 1'b1);
    #3;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    #3;
    checkOutput("clr_only_ovf", longint'(ovf_sticky), 0);
    checkOutput("clr_only_cnt", longint'(sat_cnt), 0);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    #3;
    applyStimulus(4'b0000, 1'b1, 1'b0);
    a_op[0] = 16'sd5; b_op[0] = 13'sd3;
    #3;
    checkOutput("resat_cnt", longint'(sat_cnt), 1);

    // Asynchronous reset in the middle of a burst.
    applyStimulus(4'hF, 1'b1, 1'b0);
    #3;
    applyStimulus(4'hF, 1'b1, 1'b0);
    #3;
    checkOutput("burst_rsp_valid", longint'(rsp_valid), 1);
    ap_rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", longint'(rsp_valid), 0);
    checkOutput("async_rst_cnt", longint'(sat_cnt), 0);
    checkOutput("async_rst_ovf", longint'(ovf_sticky), 0);
    checkOutput("async_rst_ready", longint'(req_ready), 0);
    @(posedge ap_clk); #1;
    applyStimulus(4'hF, 1'b1, 1'b0);
    ap_rst = 1'b0;
    #3;
    checkOutput("post_rst_grant", longint'(req_ready), 1);
    applyStimulus(4'h0, 1'b1, 1'b0);
    #3;
    checkOutput("post_rst_id", longint'(rsp_id), 0);
    checkOutput("post_rst_data", longint'($signed(rsp_data)), 15);
    applyStimulus(4'h0, 1'b1, 1'b0);
    #3;
    checkOutput("drain_valid", longint'(rsp_valid), 0);

    @(negedge ap_clk); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
